// File: rtl/flap_scheduler.sv
// -----------------------------------------------------------------------------
// flap_scheduler
//
// Frame-level controller sitting between the camera pixel stream and the game
// FSM. For every frame it counts dark pixels in a left and a right measurement
// window, latches both counts at frame end and pulses frame_done. A frame whose
// (right - left) dark count reaches THRESH is a "hit". After CONFIRM_FRAMES
// consecutive hits (with enable high) one flap request is raised and held until
// the game FSM acknowledges it. A cooldown of COOLDOWN_FRAMES frame ends then
// blocks further requests.
//
// Ports
//   clk          pixel clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   pix_valid    x_pos / y_pos / data_in are valid this cycle
//   x_pos        pixel column (0..H_ACTIVE-1)
//   y_pos        pixel row (0..V_ACTIVE-1)
//   data_in      pixel luminance; dark when data_in[7] == 0
//   enable       decision enable; low blocks new decisions
//   flap_ack     game FSM accepted the flap request
//   flap_req     flap request, held until acknowledged
//   frame_done   one-cycle pulse, left_count / right_count are valid
//   left_count   latched left-window dark count of the last frame
//   right_count  latched right-window dark count of the last frame
//   state        FSM state: IDLE=0, ARM=1, REQ=2, COOL=3
// -----------------------------------------------------------------------------
module flap_scheduler #(
   parameter int H_ACTIVE        = 200,
   parameter int V_ACTIVE        = 164,
   parameter int X_MIDDLE        = 100,
   parameter int MARGIN          = 5,
   parameter int THRESH          = 300,
   parameter int CONFIRM_FRAMES  = 2,
   parameter int COOLDOWN_FRAMES = 8,
   parameter int COUNT_W         = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pix_valid,
   input  logic [10:0]        x_pos,
   input  logic [10:0]        y_pos,
   input  logic [7:0]         data_in,
   input  logic               enable,
   input  logic               flap_ack,
   output logic               flap_req,
   output logic               frame_done,
   output logic [COUNT_W-1:0] left_count,
   output logic [COUNT_W-1:0] right_count,
   output logic [1:0]         state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      REQ  = 2'd2,
      COOL = 2'd3
   } state_t;

   localparam int HIT_W  = $clog2(CONFIRM_FRAMES + 1);
   localparam int COOL_W = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

   localparam logic [10:0] X_LAST  = 11'(H_ACTIVE - 1);
   localparam logic [10:0] Y_LAST  = 11'(V_ACTIVE - 1);
   localparam logic [10:0] X_LO    = 11'(MARGIN);
   localparam logic [10:0] X_MID   = 11'(X_MIDDLE);
   localparam logic [10:0] X_HI    = 11'(H_ACTIVE - MARGIN);
   localparam logic [10:0] Y_LO    = 11'(MARGIN);
   localparam logic [10:0] Y_HI    = 11'(V_ACTIVE - MARGIN);

   localparam logic signed [COUNT_W:0] THRESH_S  = (COUNT_W + 1)'(THRESH);
   localparam logic [HIT_W-1:0]        CONFIRM_N = HIT_W'(CONFIRM_FRAMES);
   localparam logic [COOL_W-1:0]       COOL_N    = COOL_W'(COOLDOWN_FRAMES);

   // Saturating increment: the accumulator sticks at all-ones instead of wrapping.
   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
      return (&v) ? v : v + COUNT_W'(1);
   endfunction

   // ---- Stage p0: pixel classification and running accumulators ----
   logic               frame_start_p0;
   logic               frame_end_p0;
   logic               y_in_p0;
   logic               in_left_p0;
   logic               in_right_p0;
   logic               dark_p0;
   logic [COUNT_W-1:0] acc_left_p0;
   logic [COUNT_W-1:0] acc_right_p0;
   logic               seen_start;

   // Only bit 7 decides darkness; the lower luminance bits are deliberately ignored.
   logic               unused_data;
   assign unused_data = ^data_in[6:0];

   assign frame_start_p0 = pix_valid && (x_pos == 11'd0) && (y_pos == 11'd0);
   assign frame_end_p0   = pix_valid && (x_pos == X_LAST) && (y_pos == Y_LAST);
   assign y_in_p0        = (y_pos > Y_LO) && (y_pos < Y_HI);
   // X_MIDDLE itself belongs to neither window (strict compares on both sides).
   assign in_left_p0     = y_in_p0 && (x_pos > X_LO)  && (x_pos < X_MID);
   assign in_right_p0    = y_in_p0 && (x_pos > X_MID) && (x_pos < X_HI);
   assign dark_p0        = ~data_in[7];

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_left_p0  <= '0;
         acc_right_p0 <= '0;
         left_count   <= '0;
         right_count  <= '0;
         frame_done   <= 1'b0;
         seen_start   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (frame_start_p0) begin
            acc_left_p0  <= '0;
            acc_right_p0 <= '0;
            seen_start   <= 1'b1;
         end else if (pix_valid && dark_p0) begin
            if (in_left_p0)  acc_left_p0  <= sat_inc(acc_left_p0);
            if (in_right_p0) acc_right_p0 <= sat_inc(acc_right_p0);
         end
         // A frame end only means something once a frame start has cleared the
         // accumulators; a partial frame after reset must not report counts.
         // The accumulators are left intact here; frame start clears them.
         if (frame_end_p0 && seen_start) begin
            left_count  <= acc_left_p0;
            right_count <= acc_right_p0;
            frame_done  <= 1'b1;
         end
      end
   end

   // ---- Stage p1: hit decision on latched counts and flap FSM ----
   logic signed [COUNT_W:0] diff_p1;
   logic                    hit_p1;

   // Zero-extend both counts so the subtraction is a true signed difference.
   assign diff_p1 = $signed({1'b0, right_count}) - $signed({1'b0, left_count});
   assign hit_p1  = (diff_p1 >= THRESH_S);

   state_t              state_q, state_nxt;
   logic [HIT_W-1:0]    hit_cnt, hit_cnt_nxt, hit_inc;
   logic [COOL_W-1:0]   cool_cnt, cool_cnt_nxt, cool_inc;

   assign hit_inc  = hit_cnt + HIT_W'(1);
   assign cool_inc = cool_cnt + COOL_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         hit_cnt  <= '0;
         cool_cnt <= '0;
      end else begin
         state_q  <= state_nxt;
         hit_cnt  <= hit_cnt_nxt;
         cool_cnt <= cool_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state_q;
      hit_cnt_nxt  = hit_cnt;
      cool_cnt_nxt = cool_cnt;
      case (state_q)
         IDLE: begin
            if (frame_done && enable && hit_p1) begin
               hit_cnt_nxt = HIT_W'(1);
               if (CONFIRM_FRAMES == 1) state_nxt = REQ;
               else                     state_nxt = ARM;
            end
         end
         ARM: begin
            if (frame_done) begin
               if (!enable || !hit_p1) begin
                  state_nxt   = IDLE;
                  hit_cnt_nxt = '0;
               end else begin
                  hit_cnt_nxt = hit_inc;
                  if (hit_inc == CONFIRM_N) state_nxt = REQ;
               end
            end
         end
         REQ: begin
            // Frame ends and enable are irrelevant here; only the ack releases.
            if (flap_ack) begin
               state_nxt    = COOL;
               cool_cnt_nxt = '0;
               hit_cnt_nxt  = '0;
            end
         end
         COOL: begin
            if (COOLDOWN_FRAMES == 0) begin
               state_nxt = IDLE;
            end else if (frame_done) begin
               cool_cnt_nxt = cool_inc;
               if (cool_inc >= COOL_N) state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt    = IDLE;
            hit_cnt_nxt  = '0;
            cool_cnt_nxt = '0;
         end
      endcase
   end

   assign flap_req = (state_q == REQ);
   assign state    = state_q;

endmodule

// File: tb/tb_flap_scheduler.sv
module tb_flap_scheduler;

   localparam int COUNT_W = 15;

   logic               clk = 1'b0;
   logic               rst;
   logic               pix_valid;
   logic [10:0]        x_pos;
   logic [10:0]        y_pos;
   logic [7:0]         data_in;
   logic               enable;
   logic               flap_ack;
   logic               flap_req;
   logic               frame_done;
   logic [COUNT_W-1:0] left_count;
   logic [COUNT_W-1:0] right_count;
   logic [1:0]         state;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   flap_scheduler #(
      .H_ACTIVE(200), .V_ACTIVE(164), .X_MIDDLE(100), .MARGIN(5),
      .THRESH(300), .CONFIRM_FRAMES(2), .COOLDOWN_FRAMES(8), .COUNT_W(COUNT_W)
   ) dut (
      .clk(clk), .rst(rst), .pix_valid(pix_valid), .x_pos(x_pos), .y_pos(y_pos),
      .data_in(data_in), .enable(enable), .flap_ack(flap_ack),
      .flap_req(flap_req), .frame_done(frame_done),
      .left_count(left_count), .right_count(right_count), .state(state)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pixel(input int x, input int y, input logic [7:0] d);
      pix_valid = 1'b1;
      x_pos     = 11'(x);
      y_pos     = 11'(y);
      data_in   = d;
      tick();
      pix_valid = 1'b0;
   endtask

   // One frame: start pixel, dark pixels just outside every window edge, an
   // invalid dark in-window cycle, nl left / nr right / nmid column-100 dark
   // pixels, then the (dark, out-of-window) frame-end pixel.
   task automatic send_frame(input string tag, input int nl, input int nr, input int nmid,
                             input int exp_l, input int exp_r, input logic exp_req_fd);
      pixel(0, 0, 8'hFF);
      pixel(5, 50, 8'h00);
      pixel(100, 50, 8'h00);
      pixel(195, 50, 8'h00);
      pixel(50, 5, 8'h00);
      pixel(150, 159, 8'h00);
      pixel(6, 6, 8'h80);
      pix_valid = 1'b0; x_pos = 11'd50; y_pos = 11'd50; data_in = 8'h00;
      tick();
      for (int i = 0; i < nl; i++)
         pixel(6 + (i % 94), 6 + (i / 94), (i % 2) ? 8'h7F : 8'h00);
      for (int i = 0; i < nr; i++)
         pixel(101 + (i % 94), 6 + (i / 94), (i % 2) ? 8'h7F : 8'h00);
      for (int i = 0; i < nmid; i++)
         pixel(100, 6 + i, 8'h00);
      pixel(199, 163, 8'h00);
      check_eq({tag, ".fd_hi"}, frame_done, 1);
      check_eq({tag, ".left"}, left_count, exp_l);
      check_eq({tag, ".right"}, right_count, exp_r);
      check_eq({tag, ".req_at_fd"}, flap_req, exp_req_fd);
      tick();
      check_eq({tag, ".fd_lo"}, frame_done, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; pix_valid = 1'b0; x_pos = '0; y_pos = '0; data_in = 8'hFF;
      enable = 1'b1; flap_ack = 1'b0;
      tick(); tick();
      check_eq("rst.req", flap_req, 0);
      check_eq("rst.fd", frame_done, 0);
      check_eq("rst.left", left_count, 0);
      check_eq("rst.right", right_count, 0);
      check_eq("rst.state", state, 0);
      rst = 1'b0;

      // Frame end without a preceding frame start is not reported.
      pixel(199, 163, 8'h00);
      check_eq("nostart.fd", frame_done, 0);
      tick();

      // White frame (only out-of-window dark pixels).
      send_frame("white", 0, 0, 0, 0, 0, 1'b0);
      check_eq("white.state", state, 0);
      check_eq("white.req", flap_req, 0);

      // Right half fully dark, two frames.
      send_frame("rh1", 0, 14382, 0, 0, 14382, 1'b0);
      check_eq("rh1.state", state, 1);
      check_eq("rh1.req", flap_req, 0);
      send_frame("rh2", 0, 14382, 0, 0, 14382, 1'b0);
      check_eq("rh2.req", flap_req, 1);
      check_eq("rh2.state", state, 2);
      for (int i = 0; i < 10; i++) begin
         enable = (i < 5);
         tick();
         check_eq("hold.req", flap_req, 1);
      end
      enable = 1'b1;
      send_frame("overlap", 0, 7, 0, 0, 7, 1'b1);
      check_eq("overlap.req", flap_req, 1);
      check_eq("overlap.state", state, 2);
      flap_ack = 1'b1;
      tick();
      flap_ack = 1'b0;
      check_eq("ack.req", flap_req, 0);
      check_eq("ack.state", state, 3);

      // Cooldown with continuous diff=300 hit frames.
      for (int f = 1; f <= 10; f++) begin
         send_frame("cool", 0, 300, 0, 0, 300, 1'b0);
         check_eq("cool.state", state, (f < 8) ? 3 : (f == 8) ? 0 : (f == 9) ? 1 : 2);
         check_eq("cool.req", flap_req, (f == 10) ? 1 : 0);
         if (f == 1) begin
            flap_ack = 1'b1;
            tick();
            flap_ack = 1'b0;
            check_eq("cool.ack_ignored", state, 3);
         end
      end
      // Ack already high on the first REQ cycle: request lasts one cycle.
      flap_ack = 1'b1;
      tick();
      flap_ack = 1'b0;
      check_eq("ack1.req", flap_req, 0);
      check_eq("ack1.state", state, 3);
      for (int f = 1; f <= 8; f++) begin
         send_frame("drain", 0, 0, 0, 0, 0, 1'b0);
         check_eq("drain.state", state, (f < 8) ? 3 : 0);
      end

      // One hit frame then a white frame.
      send_frame("hw1", 0, 300, 0, 0, 300, 1'b0);
      check_eq("hw1.state", state, 1);
      send_frame("hw2", 0, 0, 0, 0, 0, 1'b0);
      check_eq("hw2.state", state, 0);
      check_eq("hw2.req", flap_req, 0);

      // diff = 299 never hits.
      send_frame("d299a", 0, 299, 0, 0, 299, 1'b0);
      check_eq("d299a.state", state, 0);
      send_frame("d299b", 1, 300, 0, 1, 300, 1'b0);
      check_eq("d299b.state", state, 0);

      // Negative diff never hits.
      send_frame("l500a", 500, 0, 0, 500, 0, 1'b0);
      check_eq("l500a.state", state, 0);
      send_frame("l500b", 500, 0, 0, 500, 0, 1'b0);
      check_eq("l500b.state", state, 0);
      check_eq("l500b.req", flap_req, 0);

      // Dark pixels only in the split column.
      send_frame("mid", 0, 0, 153, 0, 0, 1'b0);
      check_eq("mid.state", state, 0);

      // enable gating in IDLE and ARM.
      enable = 1'b0;
      send_frame("en0", 0, 300, 0, 0, 300, 1'b0);
      check_eq("en0.state", state, 0);
      enable = 1'b1;
      send_frame("en1", 0, 300, 0, 0, 300, 1'b0);
      check_eq("en1.state", state, 1);
      enable = 1'b0;
      send_frame("en2", 0, 300, 0, 0, 300, 1'b0);
      check_eq("en2.state", state, 0);
      enable = 1'b1;

      // Ack outside REQ is ignored.
      flap_ack = 1'b1;
      tick();
      flap_ack = 1'b0;
      check_eq("idle_ack.state", state, 0);
      check_eq("idle_ack.req", flap_req, 0);

      // Reset mid-handshake and mid-frame.
      send_frame("r1", 0, 300, 0, 0, 300, 1'b0);
      send_frame("r2", 0, 300, 0, 0, 300, 1'b0);
      check_eq("r2.req", flap_req, 1);
      pixel(0, 0, 8'hFF);
      pixel(101, 6, 8'h00);
      pixel(102, 6, 8'h00);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("rstmid.req", flap_req, 0);
      check_eq("rstmid.left", left_count, 0);
      check_eq("rstmid.right", right_count, 0);
      check_eq("rstmid.state", state, 0);
      check_eq("rstmid.fd", frame_done, 0);
      pixel(103, 6, 8'h00);
      pixel(199, 163, 8'h00);
      check_eq("rstmid.end_fd", frame_done, 0);
      tick();
      check_eq("rstmid.end_fd2", frame_done, 0);
      send_frame("post", 0, 5, 0, 0, 5, 1'b0);
      check_eq("post.state", state, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
